regfile_wb_sink: RTL and testbench
==================================

// Module: regfile_wb_sink
// PURPOSE
// - Register file that consumes the write-back bus: busW and destination Rw are driven by the
//   MemtoReg write-back select, one write per clock.
// - Two combinational read ports, busA and busB, feed the ALU operand path of the single-cycle CPU.
// - Storage is RAM-style and cannot be cleared in parallel. A sequential clear sweep after reset
//   zeroes every register; ready gates the core until the sweep is done.
// PARAMETERS
// - DATA_W   32   width of busW, busA, busB
// - ADDR_W   5    register index width; NREG = 2**ADDR_W registers, r0 hardwired to 0
// PORTS
// - clk     in   1       system clock; all state updates on the rising edge
// - rst     in   1       synchronous, active-high reset
// - RegWr   in   1       write enable from control
// - Rw      in   ADDR_W  destination register index
// - busW    in   DATA_W  write-back data (output of the MemtoReg select)
// - Ra      in   ADDR_W  read port A index
// - Rb      in   ADDR_W  read port B index
// - busA    out  DATA_W  read data A (combinational)
// - busB    out  DATA_W  read data B (combinational)
// - ready   out  1       1 = clear sweep done, writes accepted
// BEHAVIOUR
// - Clock and reset: one clock, clk. rst is synchronous and active-high.
// - FSM states are CLEAR and RUN. A clock edge with rst=1 sets state=CLEAR and idx=1.
// - CLEAR, each edge with rst=0:
//   - mem[idx] <= 0, idx <= idx+1.
//   - When idx==NREG-1 is written, the next state is RUN.
//   - The sweep is NREG-1 cycles: 31 with default parameters.
// - ready = (state==RUN), registered.
//   - ready is 0 during rst and during CLEAR.
//   - ready first reads 1 on the edge that follows the write of mem[NREG-1].
// - In CLEAR:
//   - RegWr is ignored.
//   - busA = busB = 0 regardless of Ra/Rb.
// - In RUN:
//   - Write: if RegWr=1 and Rw!=0, mem[Rw] <= busW on the edge.
//   - Write to r0: RegWr=1 with Rw==0 is dropped silently.
//   - Read: busA = (Ra==0) ? 0 : mem[Ra]; busB likewise with Rb. Reads are combinational, zero latency.
//   - Ra==Rb is legal; both ports return the same value.
// - Reset mid-sweep: rst=1 at any point forces CLEAR, idx=1, ready=0. The full sweep restarts.
// - Reset in RUN: same as reset mid-sweep. All contents are treated as lost and are re-cleared by the sweep.
// - idx is ADDR_W bits wide and never wraps. Leaving CLEAR happens before idx could overflow.
// - No X may propagate to busA/busB after ready=1, including for registers never written.
// CONFIGURATION
// - Macro REGFILE_BYPASS_EN defined: write-to-read forwarding.
//   - In RUN, if RegWr=1, Rw!=0 and Ra==Rw, then busA = busW in the same cycle. busB behaves the same for Rb.
//   - The r0 rule still wins: Ra==0 gives 0 even when Rw==0.
// - Macro not defined: no forwarding.
//   - A read of Rw in the write cycle returns the old mem[Rw].
//   - The new value is visible from the cycle after the edge.
// - The macro affects no other behaviour; the sweep and ready timing are identical in both builds.
// TESTING
// - Reset sweep: rst=1 for 1 cycle, then 0. Required: ready=0 for exactly 31 edges, then 1.
//   Then Ra=0..31 all read 0.
// - Write/read: in RUN, RegWr=1, Rw=5, busW=32'hDEADBEEF for one edge. Required: Ra=5 gives
//   busA=32'hDEADBEEF, and Rb=5 gives busB=32'hDEADBEEF.
// - r0 immutability: RegWr=1, Rw=0, busW=32'hFFFFFFFF. Required: Ra=0 gives busA=0, and no
//   other register changes.
// - Writes during CLEAR: at sweep cycle 10, RegWr=1, Rw=3, busW=32'h12345678. Required: after
//   ready=1, Ra=3 gives 0.
// - Reset mid-sweep: assert rst at sweep cycle 20. Required: ready stays 0 for a further 31
//   edges after rst drops.
// - Bypass: write Rw=7, busW=32'hA5A5A5A5 with Ra=7 while mem[7]=32'h1. Required: busA=32'hA5A5A5A5
//   in that cycle with REGFILE_BYPASS_EN defined, and 32'h1 without it. busA=32'hA5A5A5A5 on the
//   next cycle in both builds.

Source files
------------

// File: rtl/regfile_wb_sink.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_sink
// Description : Write-back register file with two combinational read ports and
//               a post-reset clear sweep (RAM-style storage, r0 hardwired to 0).
//               Optional write-to-read forwarding under macro REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_sink #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWr,
  input  logic [ADDR_W-1:0] Rw,
  input  logic [DATA_W-1:0] busW,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic              ready
);

  localparam int NREG = 2 ** ADDR_W;

  localparam logic [0:0] c_state_clear = 1'b0;
  localparam logic [0:0] c_state_run   = 1'b1;

  localparam logic [ADDR_W-1:0] c_idx_first = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_idx_last  = ADDR_W'(NREG - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_ready;
  logic [DATA_W-1:0] r_mem [NREG];

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_run;
  logic              w_wr_live;

  assign w_run     = (r_state == c_state_run);
  assign w_wr_live = w_run && RegWr && (Rw != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_state_clear;
      r_idx   <= c_idx_first;
      r_ready <= 1'b0;
    end else begin
      // ready lags the state by one edge so it rises after the last clear write
      r_ready <= w_run;
      if (r_state == c_state_clear) begin
        if (r_idx == c_idx_last) begin
          r_state <= c_state_run;
        end else begin
          r_idx <= r_idx + ADDR_W'(1);
        end
      end
    end
  end

  // Single shared write port: the sweep and the write-back bus never overlap
  always_comb begin
    w_we    = 1'b0;
    w_waddr = Rw;
    w_wdata = busW;
    if (!rst) begin
      if (r_state == c_state_clear) begin
        w_we    = 1'b1;
        w_waddr = r_idx;
        w_wdata = '0;
      end else begin
        w_we = w_wr_live;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_comb begin
    busA = '0;
    if (w_run && (Ra != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (w_wr_live && (Ra == Rw)) begin
        busA = busW;
      end else begin
        busA = r_mem[Ra];
      end
`else
      busA = r_mem[Ra];
`endif
    end
  end

  always_comb begin
    busB = '0;
    if (w_run && (Rb != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (w_wr_live && (Rb == Rw)) begin
        busB = busW;
      end else begin
        busB = r_mem[Rb];
      end
`else
      busB = r_mem[Rb];
`endif
    end
  end

  assign ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_sink
// Description : Scoreboard bench for regfile_wb_sink (sweep, write/read, r0,
//               writes during clear, reset mid-sweep, forwarding).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_sink;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clk;
  logic              rst;
  logic              RegWr;
  logic [ADDR_W-1:0] Rw;
  logic [DATA_W-1:0] busW;
  logic [ADDR_W-1:0] Ra;
  logic [ADDR_W-1:0] Rb;
  logic [DATA_W-1:0] busA;
  logic [DATA_W-1:0] busB;
  logic              ready;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] model [NREG];

  regfile_wb_sink #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .RegWr (RegWr),
    .Rw    (Rw),
    .busW  (busW),
    .Ra    (Ra),
    .Rb    (Rb),
    .busA  (busA),
    .busB  (busB),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_cmp(input string tag, input logic [DATA_W-1:0] obs);
    logic [DATA_W-1:0] e;
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check(tag, obs, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect ready=0 for n edges, then ready=1 on the next edge
  task automatic expect_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      push_exp(0);
      tick();
      pop_cmp("ready_low", {31'b0, ready});
    end
    push_exp(1);
    tick();
    pop_cmp("ready_high", {31'b0, ready});
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    RegWr = 1'b1; Rw = a; busW = d;
    tick();
    RegWr = 1'b0;
    if (a != 0) model[a] = d;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < NREG; i++) begin
      Ra = ADDR_W'(i); Rb = ADDR_W'(NREG - 1 - i);
      push_exp(model[i]);
      push_exp(model[NREG - 1 - i]);
      #1;
      pop_cmp({tag, "_A"}, busA);
      pop_cmp({tag, "_B"}, busB);
    end
  endtask

  initial begin
    rst = 1'b1; RegWr = 1'b0; Rw = '0; busW = '0; Ra = '0; Rb = '0;
    for (int i = 0; i < NREG; i++) model[i] = '0;

    // Reset state and sweep, with a write attempt at sweep cycle 10
    tick();
    push_exp(0);
    pop_cmp("reset_ready", {31'b0, ready});
    rst = 1'b0;
    Ra = 5'd5; Rb = 5'd31;
    for (int i = 1; i <= 31; i++) begin
      if (i == 10) begin RegWr = 1'b1; Rw = 5'd3; busW = 32'h12345678; Ra = 5'd3; end
      else RegWr = 1'b0;
      push_exp(0);
      push_exp(0);
      #1;
      pop_cmp("clear_busA", busA);
      pop_cmp("clear_busB", busB);
      push_exp(0);
      tick();
      pop_cmp("sweep_ready", {31'b0, ready});
    end
    RegWr = 1'b0;
    push_exp(1);
    tick();
    pop_cmp("sweep_done", {31'b0, ready});
    read_all("post_sweep");

    // Write/read on both ports
    write_reg(5'd5, 32'hDEADBEEF);
    Ra = 5'd5; Rb = 5'd5;
    push_exp(32'hDEADBEEF); push_exp(32'hDEADBEEF);
    #1;
    pop_cmp("wr5_A", busA);
    pop_cmp("wr5_B", busB);

    // r0 immutability
    write_reg(5'd0, 32'hFFFFFFFF);
    read_all("r0_write");

    // Forwarding behaviour
    write_reg(5'd7, 32'h1);
    RegWr = 1'b1; Rw = 5'd7; busW = 32'hA5A5A5A5; Ra = 5'd7; Rb = 5'd0;
`ifdef REGFILE_BYPASS_EN
    push_exp(32'hA5A5A5A5);
`else
    push_exp(32'h1);
`endif
    push_exp(0);
    #1;
    pop_cmp("byp_same_cycle", busA);
    pop_cmp("byp_r0", busB);
    tick();
    RegWr = 1'b0;
    model[7] = 32'hA5A5A5A5;
    push_exp(32'hA5A5A5A5);
    #1;
    pop_cmp("byp_next_cycle", busA);

    // Random writes against the model
    for (int i = 0; i < 24; i++) begin
      write_reg(ADDR_W'($urandom_range(0, NREG - 1)), $urandom);
    end
    read_all("random");

    // Reset in RUN, then reset mid-sweep at cycle 20
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    push_exp(0);
    pop_cmp("mid_ready", {31'b0, ready});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_sweep(31);
    for (int i = 0; i < NREG; i++) model[i] = '0;
    read_all("re_cleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
